// File: rtl/pito_pkg.sv
// Shared pito core definitions: CSR op encodings and MVU job-context bank types.
package pito_pkg;

    localparam logic [2:0] CSR_NONE  = 3'd0;
    localparam logic [2:0] CSR_READ  = 3'd1;
    localparam logic [2:0] CSR_WRITE = 3'd2;
    localparam logic [2:0] CSR_SET   = 3'd3;
    localparam logic [2:0] CSR_CLEAR = 3'd4;

    typedef enum logic [1:0] {
        MVU_CTX_IDLE = 2'd0,
        MVU_CTX_PEND = 2'd1,
        MVU_CTX_BUSY = 2'd2
    } mvu_ctx_state_e;

    localparam int unsigned MVU_ST_BUSY    = 0;
    localparam int unsigned MVU_ST_PEND    = 1;
    localparam int unsigned MVU_ST_QUEUED  = 2;
    localparam int unsigned MVU_ST_DONE    = 3;
    localparam int unsigned MVU_ST_OVERRUN = 4;

    localparam logic [11:0] MVU_CSR_BASE_DEFAULT = 12'hF20;

    function automatic logic [31:0] csr_apply(input logic [2:0]  op,
                                              input logic [31:0] old_v,
                                              input logic [31:0] wdata);
        case (op)
            CSR_WRITE: csr_apply = wdata;
            CSR_SET:   csr_apply = old_v | wdata;
            CSR_CLEAR: csr_apply = old_v & ~wdata;
            default:   csr_apply = old_v;
        endcase
    endfunction

endpackage

// File: rtl/rv32_mvu_hart_ctx.sv
// One hart's MVU job context: shadow/active config, launch FSM and status bits.
module rv32_mvu_hart_ctx
    import pito_pkg::*;
#(
    parameter int unsigned NUM_CFG_REGS = 24,
    parameter int unsigned IDX_W        = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_acc,
    input  logic [2:0]                   i_op,
    input  logic                         i_is_cmd,
    input  logic                         i_is_status,
    input  logic [IDX_W-1:0]             i_idx,
    input  logic [31:0]                  i_wdata,
    input  logic                         i_mvu_ready,
    input  logic                         i_mvu_done,
    output logic [31:0]                  o_rd_val,
    output logic                         o_mvu_start,
    output logic                         o_mvu_irq,
    output logic [NUM_CFG_REGS*32-1:0]   o_cfg_active,
    output logic [31:0]                  o_cmd_active
);

    logic [31:0]    r_shadow [NUM_CFG_REGS];
    logic [31:0]    r_active [NUM_CFG_REGS];
    logic [31:0]    w_sh_nxt [NUM_CFG_REGS];
    logic [31:0]    r_cmd_sh, r_cmd_act, w_cmd_nxt;
    mvu_ctx_state_e r_state, w_state_nxt;
    logic           r_queued, r_done, r_ovr;
    logic [31:0]    w_status, w_old, w_new;
    logic           w_wr, w_launch, w_w1c;
    logic           w_copy, w_q_set, w_q_clr, w_done_set, w_ovr_set;

    always_comb begin
        w_status                 = '0;
        w_status[MVU_ST_BUSY]    = (r_state != MVU_CTX_IDLE);
        w_status[MVU_ST_PEND]    = (r_state == MVU_CTX_PEND);
        w_status[MVU_ST_QUEUED]  = r_queued;
        w_status[MVU_ST_DONE]    = r_done;
        w_status[MVU_ST_OVERRUN] = r_ovr;
    end

    assign w_old    = i_is_cmd ? r_cmd_sh : (i_is_status ? w_status : r_shadow[i_idx]);
    assign w_new    = csr_apply(i_op, w_old, i_wdata);
    assign o_rd_val = w_old;
    assign w_wr     = i_acc && (i_op == CSR_WRITE || i_op == CSR_SET || i_op == CSR_CLEAR);
    assign w_launch = w_wr && i_is_cmd;
    assign w_w1c    = w_wr && i_is_status && (i_op == CSR_WRITE);
    assign w_cmd_nxt = w_launch ? w_new : r_cmd_sh;

    // The copy samples post-write shadow so a same-cycle command lands in active.
    always_comb begin
        w_sh_nxt = r_shadow;
        if (w_wr && !i_is_cmd && !i_is_status)
            w_sh_nxt[i_idx] = w_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MVU_CTX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_copy      = 1'b0;
        w_q_set     = 1'b0;
        w_q_clr     = 1'b0;
        w_done_set  = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            MVU_CTX_IDLE: begin
                if (w_launch) begin
                    w_copy      = 1'b1;
                    w_state_nxt = MVU_CTX_PEND;
                end
            end
            MVU_CTX_PEND: begin
                w_ovr_set = w_launch;
                if (i_mvu_ready)
                    w_state_nxt = MVU_CTX_BUSY;
            end
            MVU_CTX_BUSY: begin
                if (i_mvu_done) begin
                    w_done_set = 1'b1;
                    if (r_queued) begin
                        w_copy      = 1'b1;
                        w_q_clr     = 1'b1;
                        w_ovr_set   = w_launch;
                        w_state_nxt = MVU_CTX_PEND;
                    end else if (w_launch) begin
                        w_copy      = 1'b1;
                        w_state_nxt = MVU_CTX_PEND;
                    end else begin
                        w_state_nxt = MVU_CTX_IDLE;
                    end
                end else if (w_launch) begin
                    w_ovr_set = r_queued;
                    w_q_set   = !r_queued;
                end
            end
            default: w_state_nxt = MVU_CTX_IDLE;
        endcase
    end

    always_comb begin
        o_mvu_start = (r_state == MVU_CTX_PEND);
        o_mvu_irq   = r_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CFG_REGS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_cmd_sh  <= '0;
            r_cmd_act <= '0;
            r_queued  <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_shadow <= w_sh_nxt;
            r_cmd_sh <= w_cmd_nxt;
            if (w_copy) begin
                r_active  <= w_sh_nxt;
                r_cmd_act <= w_cmd_nxt;
            end
            if (w_q_set)
                r_queued <= 1'b1;
            else if (w_q_clr)
                r_queued <= 1'b0;
            r_done <= w_done_set | (r_done & ~(w_w1c & i_wdata[MVU_ST_DONE]));
            r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_w1c & i_wdata[MVU_ST_OVERRUN]));
        end
    end

    for (genvar r = 0; r < NUM_CFG_REGS; r++) begin : g_flat
        assign o_cfg_active[r*32 +: 32] = r_active[r];
    end
    assign o_cmd_active = r_cmd_act;

endmodule

// File: rtl/rv32_barrel_mvu_ctxbank.sv
// Per-hart MVU job-context bank: CSR decode, hart routing and registered read path.
module rv32_barrel_mvu_ctxbank
    import pito_pkg::*;
#(
    parameter int unsigned NUM_HARTS    = 8,
    parameter int unsigned NUM_CFG_REGS = 24,
    parameter logic [11:0] CSR_BASE     = MVU_CSR_BASE_DEFAULT,
    localparam int unsigned HART_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [HART_W-1:0]                    hart_id_i,
    input  logic [11:0]                          csr_addr,
    input  logic [2:0]                           csr_op,
    input  logic [31:0]                          csr_wdata,
    output logic [31:0]                          csr_rdata,
    output logic                                 csr_illegal,
    input  logic [NUM_HARTS-1:0]                 mvu_ready,
    input  logic [NUM_HARTS-1:0]                 mvu_done,
    output logic [NUM_HARTS-1:0]                 mvu_start,
    output logic [NUM_HARTS*NUM_CFG_REGS*32-1:0] cfg_active,
    output logic [NUM_HARTS*32-1:0]              cmd_active,
    output logic [NUM_HARTS-1:0]                 mvu_irq
);

    localparam int unsigned IDX_W = (NUM_CFG_REGS > 1) ? $clog2(NUM_CFG_REGS) : 1;

    logic [11:0]      w_off;
    logic             w_is_cfg, w_is_cmd, w_is_status;
    logic             w_access, w_hart_ok, w_bad_op, w_illegal, w_legal;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_vals [NUM_HARTS];
    logic [31:0]      w_rd_sel;
    logic [31:0]      r_rdata;
    logic             r_illegal;

    // Offset arithmetic wraps, so addresses below the base fall out of range too.
    assign w_off       = csr_addr - CSR_BASE;
    assign w_is_cfg    = (w_off < 12'(NUM_CFG_REGS));
    assign w_is_cmd    = (w_off == 12'(NUM_CFG_REGS));
    assign w_is_status = (w_off == 12'(NUM_CFG_REGS + 1));
    assign w_access    = (csr_op == CSR_READ) || (csr_op == CSR_WRITE) ||
                         (csr_op == CSR_SET)  || (csr_op == CSR_CLEAR);
    assign w_hart_ok   = (32'(hart_id_i) < NUM_HARTS);
    assign w_bad_op    = w_is_status && ((csr_op == CSR_SET) || (csr_op == CSR_CLEAR));
    assign w_illegal   = w_access && (!(w_is_cfg || w_is_cmd || w_is_status) || !w_hart_ok || w_bad_op);
    assign w_legal     = w_access && !w_illegal;
    assign w_idx       = w_is_cfg ? w_off[IDX_W-1:0] : '0;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        rv32_mvu_hart_ctx #(
            .NUM_CFG_REGS (NUM_CFG_REGS),
            .IDX_W        (IDX_W)
        ) u_ctx (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_acc        (w_legal && (hart_id_i == HART_W'(h))),
            .i_op         (csr_op),
            .i_is_cmd     (w_is_cmd),
            .i_is_status  (w_is_status),
            .i_idx        (w_idx),
            .i_wdata      (csr_wdata),
            .i_mvu_ready  (mvu_ready[h]),
            .i_mvu_done   (mvu_done[h]),
            .o_rd_val     (w_rd_vals[h]),
            .o_mvu_start  (mvu_start[h]),
            .o_mvu_irq    (mvu_irq[h]),
            .o_cfg_active (cfg_active[h*NUM_CFG_REGS*32 +: NUM_CFG_REGS*32]),
            .o_cmd_active (cmd_active[h*32 +: 32])
        );
    end

    always_comb begin
        w_rd_sel = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (32'(hart_id_i) == h)
                w_rd_sel = w_rd_vals[h];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_rdata   <= w_legal ? w_rd_sel : '0;
            r_illegal <= w_illegal;
        end
    end

    assign csr_rdata   = r_rdata;
    assign csr_illegal = r_illegal;

endmodule
